id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register fed by the register file read ports and the decoder.
//  Captures decoded fields and operands into EX and bypasses same-cycle writeback data.
//  Detects load-use hazards, inserts one bubble and stalls decode.
//  Honours EX back-pressure and branch flush, and counts load-use bubbles.
// PARAMETERS
//  CTRL_W  16  width of opaque EX/MEM/WB control bundle passed through
//  CNT_W   32  width of saturating load-use bubble counter
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous reset, active-high
//  id_valid       in   1       decode slot holds a real instruction
//  id_pc          in   32      PC of decode instruction
//  id_rs1/id_rs2  in   5       source register indices (also drive regfile read addrs)
//  id_uses_rs1/2  in   1       instruction actually reads rs1 / rs2
//  id_rd          in   5       destination index
//  id_imm         in   32      sign-extended immediate
//  id_ctrl        in   CTRL_W  control bundle
//  id_mem_read    in   1       instruction is a load
//  id_reg_write   in   1       instruction writes rd
//  rf_rs1_val     in   32      register file read data, rs1 (x0 already reads 0)
//  rf_rs2_val     in   32      register file read data, rs2
//  wb_rd          in   5       writeback destination (same as regfile write port)
//  wb_data        in   32      writeback data
//  wb_reg_write   in   1       writeback enable
//  ex_ready       in   1       EX can accept a new instruction this cycle
//  flush          in   1       one-cycle pulse: kill instruction in decode
//  id_stall       out  1       hold PC and IF/ID register (combinational)
//  ex_valid       out  1       EX slot valid
//  ex_pc, ex_imm  out  32      registered copies
//  ex_rs1_val/ex_rs2_val out 32 registered bypassed operands
//  ex_rs1/ex_rs2/ex_rd out 5   registered indices (for EX forwarding unit)
//  ex_ctrl        out  CTRL_W  registered control bundle
//  ex_mem_read    out  1       registered, qualified by valid
//  ex_reg_write   out  1       registered, qualified by valid
//  lu_bubble_cnt  out  CNT_W   load-use bubbles inserted, saturates at all-ones
// BEHAVIOUR
//  Reset: every registered output 0, flush_pend 0; id_stall = !ex_ready.
//  Operand bypass per source s: s==0 -> 0; else if wb_reg_write && wb_rd==s -> wb_data;
//   else rf value. Compensates for the regfile not being write-through.
//  hazard = ex_valid && ex_mem_read && ex_rd!=0 && id_valid &&
//   ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
//  id_stall = !ex_ready || hazard.
//  Register update priority each clock (rst highest):
//   1 !ex_ready: hold all ex_* outputs; if flush, set flush_pend.
//   2 flush || flush_pend: bubble; clear flush_pend.
//   3 hazard: bubble; lu_bubble_cnt +1 (saturating).
//   4 else: capture all id_* with bypassed operands; ex_valid<=id_valid;
//     ex_mem_read/ex_reg_write <= field && id_valid.
//  Bubble: ex_valid, ex_mem_read, ex_reg_write <= 0; other ex_* fields hold.
//  Latency: one cycle ID->EX. A load-use pair costs exactly one bubble: after
//   the bubble ex_valid=0, so hazard drops and the consumer is captured.
//  flush is never lost: if it arrives during back-pressure it is applied on the
//   first cycle with ex_ready=1.
//  rst mid-stall or mid-flush-pending: all state cleared, no pending action.
// TESTING
//  T1 wb_reg_write=1, wb_rd=5, wb_data=0xDEAD_BEEF, id_rs1=5, rf_rs1_val=0x1
//     -> next cycle ex_rs1_val=0xDEAD_BEEF.
//  T2 EX holds lw x7 (ex_mem_read=1), ID holds add x8,x7,x1
//     -> id_stall=1 for one cycle, one bubble, then add is captured.
//     -> lu_bubble_cnt goes 0 to 1.
//  T3 Same pair, but id_uses_rs1=0 (or ex_rd=0) -> no stall, cnt unchanged.
//  T4 ex_ready=0 for 3 cycles with flush pulsed in the 2nd
//     -> ex_* held, id_stall=1 throughout.
//     -> first cycle with ex_ready=1 gives ex_valid=0.
//  T5 id_rs2=0, wb_rd=0, wb_reg_write=1, wb_data=0x55 -> ex_rs2_val=0.
//  T6 lu_bubble_cnt preset to all-ones via CNT_W=4 plus 16 hazards
//     -> counter stays 0xF.
//  T7 rst asserted during flush_pend=1 -> all outputs 0.
//     -> next valid ID instruction is captured normally.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/regfile/writeback and the ID/EX register.
// Handshake: the decode instruction advances into EX on a clock edge where id_valid && !id_stall;
// the EX slot is consumed on an edge where ex_valid && ex_ready, and ex_* hold while ex_ready is low.
interface id_ex_stage_if #(
    parameter int CTRL_W = 16
);
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [4:0]        id_rd;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read;
    logic              id_reg_write;
    logic [31:0]       rf_rs1_val;
    logic [31:0]       rf_rs2_val;
    logic [4:0]        wb_rd;
    logic [31:0]       wb_data;
    logic              wb_reg_write;
    logic              ex_ready;
    logic              flush;
    logic              id_stall;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_rs1_val;
    logic [31:0]       ex_rs2_val;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_mem_read;
    logic              ex_reg_write;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_imm,
               id_ctrl, id_mem_read, id_reg_write, rf_rs1_val, rf_rs2_val,
               wb_rd, wb_data, wb_reg_write, ex_ready, flush,
        input  id_stall, ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_mem_read, ex_reg_write
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd, id_imm,
               id_ctrl, id_mem_read, id_reg_write, rf_rs1_val, rf_rs2_val,
               wb_rd, wb_data, wb_reg_write, ex_ready, flush,
        output id_stall, ex_valid, ex_pc, ex_imm, ex_rs1_val, ex_rs2_val,
               ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_mem_read, ex_reg_write
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: writeback bypass into operands, one-bubble load-use
// interlock, EX back-pressure, sticky branch flush and a saturating bubble counter.
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_stage_if.slave     bus,
    output logic [CNT_W-1:0] lu_bubble_cnt,
    output logic             flush_pend
);

    logic              hazard;
    logic [31:0]       rs1_byp;
    logic [31:0]       rs2_byp;
    logic [CTRL_W-1:0] ctrl_d;

    // The regfile is not write-through, so same-cycle writeback must be forwarded here.
    function automatic logic [31:0] bypass(input logic [4:0]  src,
                                           input logic [31:0] rf_val,
                                           input logic        wb_we,
                                           input logic [4:0]  wb_dst,
                                           input logic [31:0] wb_val);
        if (src == 5'd0)
            return 32'd0;
        else if (wb_we && (wb_dst == src))
            return wb_val;
        else
            return rf_val;
    endfunction

    assign ctrl_d  = bus.id_ctrl;
    assign rs1_byp = bypass(bus.id_rs1, bus.rf_rs1_val, bus.wb_reg_write, bus.wb_rd, bus.wb_data);
    assign rs2_byp = bypass(bus.id_rs2, bus.rf_rs2_val, bus.wb_reg_write, bus.wb_rd, bus.wb_data);

    always_comb begin
        hazard = 1'b0;
        if (bus.ex_valid && bus.ex_mem_read && (bus.ex_rd != 5'd0) && bus.id_valid)
            hazard = (bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd));
        bus.id_stall = !bus.ex_ready || hazard;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_imm       <= '0;
            bus.ex_rs1_val   <= '0;
            bus.ex_rs2_val   <= '0;
            bus.ex_rs1       <= '0;
            bus.ex_rs2       <= '0;
            bus.ex_rd        <= '0;
            bus.ex_ctrl      <= '0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            lu_bubble_cnt    <= '0;
            flush_pend       <= 1'b0;
        end else if (!bus.ex_ready) begin
            // A flush seen under back-pressure is remembered until EX can move.
            if (bus.flush)
                flush_pend <= 1'b1;
        end else if (bus.flush || flush_pend) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            flush_pend       <= 1'b0;
        end else if (hazard) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_mem_read  <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            if (lu_bubble_cnt != '1)
                lu_bubble_cnt <= lu_bubble_cnt + CNT_W'(1);
        end else begin
            bus.ex_valid     <= bus.id_valid;
            bus.ex_pc        <= bus.id_pc;
            bus.ex_imm       <= bus.id_imm;
            bus.ex_rs1_val   <= rs1_byp;
            bus.ex_rs2_val   <= rs2_byp;
            bus.ex_rs1       <= bus.id_rs1;
            bus.ex_rs2       <= bus.id_rs2;
            bus.ex_rd        <= bus.id_rd;
            bus.ex_ctrl      <= ctrl_d;
            bus.ex_mem_read  <= bus.id_mem_read && bus.id_valid;
            bus.ex_reg_write <= bus.id_reg_write && bus.id_valid;
        end
    end

endmodule
